// File: rtl/opll_output_mixer_seq.sv
// opll_output_mixer_seq: per-frame sweep of carrier/rhythm slots into melody and rhythm sums
module opll_output_mixer_seq #(
    parameter int RD_LAT    = 1,
    parameter int RHY_SHIFT = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clkena,
    input  logic [4:0]         slot,
    input  logic [1:0]         stage,
    input  logic               rhythm,
    output logic [4:0]         maddr,
    input  logic [9:0]         mdata,
    output logic signed [13:0] melody_out,
    output logic signed [13:0] rhythm_out,
    output logic               out_valid,
    output logic               busy,
    output logic               overrun
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ACC, DONE} state_t;
    state_t state, state_nx;
    logic [3:0] idx;
    logic [1:0] cnt;
    logic rhy_q, fs, last, is_rhy;
    logic [4:0] addr;
    logic signed [13:0] acc_m, acc_r, smp;
    assign fs     = clkena && slot == 5'd0 && stage == 2'd0;
    assign is_rhy = rhy_q && idx >= 4'd6;
    assign last   = idx == (rhy_q ? 4'd10 : 4'd8);
    assign addr   = is_rhy ? 5'(idx) + 5'd7 : {idx, 1'b1};
    assign smp    = mdata[9] ? -$signed({5'd0, mdata[8:0]}) : $signed({5'd0, mdata[8:0]});
    // state register
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    // next state; a frame start always restarts the sweep
    always_comb begin
        state_nx = state;
        if (fs) state_nx = ISSUE;
        else case (state)
            ISSUE:   state_nx = WAIT;
            WAIT:    state_nx = cnt == 2'd1 ? ACC : WAIT;
            ACC:     state_nx = last ? DONE : ISSUE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    // sweep datapath: address issue, read-latency wait, accumulate, publish
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            maddr      <= '0;
            melody_out <= '0;
            rhythm_out <= '0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
            idx        <= '0;
            cnt        <= '0;
            rhy_q      <= 1'b0;
            acc_m      <= '0;
            acc_r      <= '0;
        end else begin
            out_valid <= 1'b0;
            if (fs) begin
                rhy_q <= rhythm;
                acc_m <= '0;
                acc_r <= '0;
                idx   <= '0;
                busy  <= 1'b1;
                if (busy) overrun <= 1'b1;
            end else case (state)
                ISSUE: begin
                    maddr <= addr;
                    cnt   <= 2'(RD_LAT);
                end
                WAIT: cnt <= cnt - 2'd1;
                ACC: begin
                    if (is_rhy) acc_r <= acc_r + (smp <<< RHY_SHIFT);
                    else        acc_m <= acc_m + smp;
                    if (!last) idx <= idx + 4'd1;
                end
                DONE: begin
                    melody_out <= acc_m;
                    rhythm_out <= acc_r;
                    out_valid  <= 1'b1;
                    busy       <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_opll_output_mixer_seq.sv
// tb_opll_output_mixer_seq: directed checks of the mixer sweep at read latencies 1 and 3
module tb_opll_output_mixer_seq;
    logic clk = 0, reset_n = 0, clkena = 0, rhythm = 0, ld = 0, wr_en = 0;
    logic [4:0] slot = 5'd1;
    logic [1:0] stage = 2'd0;
    logic [4:0] maddr0, maddr1, lastm = 5'd0;
    logic [9:0] mdata0, mdata1, p0;
    logic [9:0] p1 [3];
    logic [9:0] mem [32];
    logic [9:0] ldv [32];
    logic [9:0] nmem [32];
    logic signed [13:0] mel0, mel1, rhy0, rhy1;
    logic ov0, ov1, busy0, busy1, orun0, orun1;
    int ncmp = 0, nfail = 0, cyc = 0, nv0 = 0, nv1 = 0, tv0 = 0, tv1 = 0, fs_cyc = 0;
    int b0, b1, t0;
    logic [4:0] trace [$];

    always #5 clk = ~clk;

    opll_output_mixer_seq #(.RD_LAT(1), .RHY_SHIFT(1)) u0 (
        .clk(clk), .reset_n(reset_n), .clkena(clkena), .slot(slot), .stage(stage),
        .rhythm(rhythm), .maddr(maddr0), .mdata(mdata0), .melody_out(mel0),
        .rhythm_out(rhy0), .out_valid(ov0), .busy(busy0), .overrun(orun0));
    opll_output_mixer_seq #(.RD_LAT(3), .RHY_SHIFT(1)) u1 (
        .clk(clk), .reset_n(reset_n), .clkena(clkena), .slot(slot), .stage(stage),
        .rhythm(rhythm), .maddr(maddr1), .mdata(mdata1), .melody_out(mel1),
        .rhythm_out(rhy1), .out_valid(ov1), .busy(busy1), .overrun(orun1));

    assign mdata0 = p0;
    assign mdata1 = p1[2];

    // output memory model: registered read pipelines, bulk load, stage-3 rewrite of the current slot
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        p0    <= mem[maddr0];
        p1[0] <= mem[maddr1];
        p1[1] <= p1[0];
        p1[2] <= p1[1];
        if (ld) for (int i = 0; i < 32; i++) mem[i] <= ldv[i];
        else if (wr_en && clkena && stage == 2'd3) mem[slot] <= nmem[slot];
    end

    // pulse counting and address trace, sampled mid-cycle
    always @(negedge clk) begin
        if (ov0) begin nv0 <= nv0 + 1; tv0 <= cyc; end
        if (ov1) begin nv1 <= nv1 + 1; tv1 <= cyc; end
        lastm <= maddr0;
        if (maddr0 != lastm) trace.push_back(maddr0);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic commit;
        ld = 1;
        tick;
        ld = 0;
    endtask

    task automatic run_frame(input int n, input logic r, input int flip);
        for (int t = 0; t < n; t++) begin
            slot   = 5'(t / 4);
            stage  = 2'(t % 4);
            clkena = 1;
            rhythm = (flip >= 0 && t >= flip) ? ~r : r;
            tick;
            if (t == 0) fs_cyc = cyc;
            if (t == 1) begin
                chk("busy0_sweep", busy0, 1);
                chk("busy1_sweep", busy1, 1);
            end
        end
        clkena = 0;
        slot   = 5'd1;
        stage  = 2'd0;
    endtask

    initial begin
        repeat (3) tick;
        chk("rst_maddr", maddr0, 0);
        chk("rst_mel", mel0, 0);
        chk("rst_rhy", rhy0, 0);
        chk("rst_valid", ov0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_overrun", orun1, 0);
        reset_n = 1;
        tick;

        for (int i = 0; i < 32; i++) ldv[i] = (i % 2 == 1) ? 10'd100 : 10'd50;
        commit;
        b0 = nv0; b1 = nv1; t0 = trace.size();
        run_frame(72, 0, -1);
        chk("mel_pulses0", nv0 - b0, 1);
        chk("mel_pulses1", nv1 - b1, 1);
        chk("mel_time0", tv0, fs_cyc + 28);
        chk("mel_time1", tv1, fs_cyc + 46);
        chk("mel_sum0", mel0, 900);
        chk("mel_sum1", mel1, 900);
        chk("mel_rhy0", rhy0, 0);
        chk("mel_busy_end", busy0, 0);
        chk("mel_trace_len", trace.size() - t0, 9);
        for (int k = 0; k < 9; k++) chk("mel_trace", trace[t0 + k], 2 * k + 1);

        for (int i = 0; i < 32; i++) ldv[i] = 10'd0;
        ldv[1] = 10'h3FF;
        ldv[3] = 10'd10;
        ldv[5] = 10'h200;
        commit;
        run_frame(72, 0, -1);
        chk("sign_sum0", mel0, -501);
        chk("sign_sum1", mel1, -501);

        for (int i = 0; i < 32; i++) ldv[i] = (i % 2 == 1 && i <= 11) ? 10'h3FF : 10'h1FF;
        commit;
        b0 = nv0; t0 = trace.size();
        run_frame(72, 1, 3);
        chk("rhy_mel0", mel0, -3066);
        chk("rhy_rhy0", rhy0, 5110);
        chk("rhy_mel1", mel1, -3066);
        chk("rhy_rhy1", rhy1, 5110);
        chk("rhy_time0", tv0, fs_cyc + 34);
        chk("rhy_time1", tv1, fs_cyc + 56);
        chk("rhy_pulses0", nv0 - b0, 1);
        chk("rhy_trace_len", trace.size() - t0, 11);
        for (int k = 0; k < 5; k++) chk("rhy_trace_tail", trace[t0 + 6 + k], 13 + k);

        for (int i = 0; i < 32; i++) ldv[i] = 10'(i);
        commit;
        run_frame(72, 0, -1);
        chk("mel2_sum0", mel0, 81);
        chk("mel2_rhy0", rhy0, 0);
        chk("mel2_rhy1", rhy1, 0);
        chk("no_overrun", orun0, 0);

        for (int i = 0; i < 32; i++) ldv[i] = 10'(2 * i);
        commit;
        b0 = nv0; b1 = nv1;
        run_frame(10, 1, -1);
        run_frame(72, 0, -1);
        chk("ovr_flag0", orun0, 1);
        chk("ovr_flag1", orun1, 1);
        chk("ovr_pulses0", nv0 - b0, 1);
        chk("ovr_pulses1", nv1 - b1, 1);
        chk("ovr_time0", tv0, fs_cyc + 28);
        chk("ovr_mel0", mel0, 162);
        chk("ovr_mel1", mel1, 162);
        chk("ovr_rhy0", rhy0, 0);

        for (int i = 0; i < 32; i++) begin
            ldv[i]  = {1'b0, 9'(10 * i)};
            nmem[i] = {1'b1, 9'(10 * i)};
        end
        commit;
        wr_en = 1;
        run_frame(72, 0, -1);
        chk("race_mel0", mel0, 810);
        chk("race_mel1", mel1, 810);
        for (int i = 0; i < 32; i++) nmem[i] = 10'd7;
        run_frame(72, 1, -1);
        wr_en = 0;
        chk("race_rmel0", mel0, -360);
        chk("race_rrhy0", rhy0, -1500);
        chk("race_rmel1", mel1, -360);
        chk("race_rrhy1", rhy1, -1500);

        run_frame(10, 0, -1);
        #2 reset_n = 0;
        #1;
        chk("mid_rst_mel0", mel0, 0);
        chk("mid_rst_rhy1", rhy1, 0);
        chk("mid_rst_busy0", busy0, 0);
        chk("mid_rst_busy1", busy1, 0);
        chk("mid_rst_overrun0", orun0, 0);
        chk("mid_rst_maddr1", maddr1, 0);
        tick;
        reset_n = 1;
        b0 = nv0; b1 = nv1;
        repeat (60) tick;
        chk("post_rst_pulses0", nv0 - b0, 0);
        chk("post_rst_pulses1", nv1 - b1, 0);
        chk("post_rst_busy0", busy0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule

// File: doc/opll_output_mixer_seq.md
Name: opll_output_mixer_seq

Overview:
- Per-sample mixing sequencer for the FM operator output memory. It is the single owner of the OutputMemory second read port (maddr/mdata).
- At each frame start it sweeps the carrier/rhythm slot addresses in a fixed order and converts sign-magnitude samples to two's complement.
- It accumulates separate melody and rhythm sums and presents them once per frame with a valid strobe to the downstream DAC/filter path.

Parameters:
RD_LAT, 1, clk cycles from maddr change to valid mdata (1..3 supported)
RHY_SHIFT, 1, left shift applied to each rhythm voice before accumulation (0..1)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
clkena  in  1  slot/stage advance enable (same qualifier as the operator pipeline)
slot  in  5  current slot 0..17
stage  in  2  current stage 0..3
rhythm  in  1  rhythm-mode flag (register 0x0E bit 5)
maddr  out  5  read address to output memory second port
mdata  in  10  read data, {sign, value[8:0]} sign-magnitude
melody_out  out  14  signed two's-complement melody sum
rhythm_out  out  14  signed two's-complement rhythm sum
out_valid  out  1  one-clk pulse when melody_out/rhythm_out are updated
busy  out  1  sweep in progress
overrun  out  1  sticky; set when a frame start aborts an unfinished sweep

Behaviour:
- Reset (reset_n=0, asynchronous): maddr=0, melody_out=0, rhythm_out=0, out_valid=0, busy=0, overrun=0, FSM=IDLE, accumulators=0. Release is synchronous to clk.
- Frame start (fs) is clkena=1 && slot=0 && stage=0, sampled on a clk edge.
- On fs: latch rhythm into rhy_q; clear both accumulators; index=0; go to ISSUE; busy=1.
- Sweep order is strictly ascending.
  - rhy_q=0: 1,3,5,7,9,11,13,15,17 (9 reads, all melody).
  - rhy_q=1: 1,3,5,7,9,11 (melody), then 13 (BD), 14 (HH), 15 (SD), 16 (TOM), 17 (CYM) (11 reads).
- Ascending order guarantees each slot is read before the operator pipeline rewrites it, at its stage 3, in the new frame. This holds for any clkena duty cycle when RD_LAT≤3.
- FSM:
  - IDLE: wait for fs.
  - ISSUE: drive maddr=addr[index]; load wait counter=RD_LAT; go to WAIT.
  - WAIT: decrement every clk (not clkena-gated); at 0 go to ACC.
  - ACC: convert mdata: sign=0 → +value; sign=1 → −value; sign=1 with value=0 → 0. Add the result to the melody accumulator, or, for rhythm addresses, add (result<<<RHY_SHIFT) to the rhythm accumulator. If this was the last index go to DONE, else index+1 and go to ISSUE.
  - DONE: melody_out<=acc_m, rhythm_out<=acc_r, out_valid=1 for exactly this clk, busy=0, go to IDLE.
- Sweep length: reads×(RD_LAT+2)+1 clks. With RD_LAT=1: 28 (melody) or 34 (rhythm) clks, well under one 72-tick frame.
- Width:
  - Melody max |9×511|=4599.
  - Rhythm max |5×511×2|=5110.
  - Both fit in 14-bit signed. Accumulators are 14-bit, no saturation needed; negative full-scale is representable.
- When rhy_q=0, rhythm_out is 0 at DONE. When rhy_q=1, slots 13..17 do not contribute to melody.
- fs while busy: abort the current sweep, set overrun=1, suppress out_valid for the aborted sweep, and restart from index 0 with the newly latched rhythm. Outputs retain their previous values.
- rhythm toggling mid-sweep has no effect; only rhy_q is used.
- overrun clears only on reset.
- maddr holds its last value in IDLE.
- reset_n asserted mid-sweep: immediate return to reset values; no out_valid.

Test Plan:
- Reset: assert reset_n=0 mid-sweep → all outputs 0 on the same edge, busy=0, no out_valid after release until the next fs.
- Melody sum: rhythm=0, odd slots each hold {0,9'd100}, clkena=1 every clk → after fs, maddr sequence 1,3,…,17; out_valid one pulse at fs+28 clks; melody_out=900, rhythm_out=0.
- Sign handling: slot1={1,511}, slot3={0,10}, slot5={1,0}, other carriers 0 → melody_out=−501; negative zero contributes nothing.
- Rhythm split: rhythm=1, slots 13..17={0,511}, slots 1..11={1,511} → rhythm_out=5110, melody_out=−3066; maddr order ends 13,14,15,16,17.
- Overrun: force a second fs 10 clks after the first (synthetic slot/stage stimulus) → overrun=1, no out_valid for the first sweep, exactly one out_valid for the second.
- Write-race ordering: clkena=1 every clk, memory model rewrites slot s at its stage 3 in the new frame → every value read equals the previous-frame value. Repeat with RD_LAT=3.
